// File: rtl/wr_fabric_pkg.sv
// Shared WR fabric types plus the bandwidth meter's constants and FSM state.
package wr_fabric_pkg;

    // Upstream fabric request (also what the meter forwards downstream).
    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic [1:0]  adr;
        logic [15:0] dat;
        logic [1:0]  sel;
    } t_wrf_sink_in;

    // Fabric response (ack/err/stall).
    typedef struct packed {
        logic ack;
        logic err;
        logic stall;
    } t_wrf_sink_out;

    typedef t_wrf_sink_in  t_wrf_source_out;
    typedef t_wrf_sink_out t_wrf_source_in;

    // Fabric address spaces: only DATA beats are metered.
    localparam logic [1:0] c_WRF_DATA   = 2'b00;
    localparam logic [1:0] c_WRF_STATUS = 2'b01;
    localparam logic [1:0] c_WRF_OOB    = 2'b10;
    localparam logic [1:0] c_WRF_USER   = 2'b11;

    localparam int c_BITS_PER_KBIT = 1000;

    // IDLE: no valid timebase; FIRST: partial interval; RUN: full intervals.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_RUN   = 2'd2
    } t_meter_state;

endpackage

// File: rtl/nic_bw_meter.sv
// Passive bandwidth meter on a WR fabric link: counts kbit and frames per
// PPS interval and publishes the last complete interval.
module nic_bw_meter
    import wr_fabric_pkg::*;
#(
    parameter int g_PPS_TIMEOUT = 70000000,
    parameter int g_CNT_WIDTH   = 32
) (
    input  logic                   clk_sys_i,
    input  logic                   rst_n_i,
    input  logic                   pps_p_i,
    input  logic                   pps_valid_i,
    input  logic                   en_i,
    input  t_wrf_sink_in           snk_i,
    output t_wrf_sink_out          snk_o,
    output t_wrf_source_out        src_o,
    input  t_wrf_source_in         src_i,
    output logic [g_CNT_WIDTH-1:0] bw_kbps_o,
    output logic [g_CNT_WIDTH-1:0] frames_o,
    output logic                   bw_valid_o,
    output logic                   upd_p_o
);

    localparam int                     c_TMO_W     = $clog2(g_PPS_TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0]     c_TMO_LIMIT = c_TMO_W'(g_PPS_TIMEOUT);
    localparam logic [c_TMO_W-1:0]     c_TMO_ONE   = c_TMO_W'(1);
    localparam logic [9:0]             c_KBIT      = 10'(c_BITS_PER_KBIT);
    localparam logic [g_CNT_WIDTH-1:0] c_CNT_MAX   = '1;
    localparam logic [g_CNT_WIDTH-1:0] c_CNT_ONE   = g_CNT_WIDTH'(1);

    t_meter_state           state, state_next;
    logic                   cyc_prev;
    logic [9:0]             acc, acc_next, acc_sum;
    logic [g_CNT_WIDTH-1:0] kbps_cnt, kbps_next, kbps_base;
    logic [g_CNT_WIDTH-1:0] frame_cnt, frame_next, frame_base;
    logic [c_TMO_W-1:0]     tmo_cnt, tmo_next;
    logic                   qpps, beat, frame_end, timeout, go_idle, load, count_en, carry;
    logic [4:0]             beat_bits;

    // The fabric is only observed, never touched: pure wires, live in reset.
    assign src_o = snk_i;
    assign snk_o = src_i;

    // Decode this cycle's events from the fabric and the timebase.
    always_comb begin
        qpps      = pps_p_i & pps_valid_i;
        beat      = snk_i.cyc & snk_i.stb & ~src_i.stall & (snk_i.adr == c_WRF_DATA);
        beat_bits = beat ? ((snk_i.sel == 2'b11) ? 5'd16 : 5'd8) : 5'd0;
        frame_end = cyc_prev & ~snk_i.cyc;
        timeout   = (state != ST_IDLE) && (tmo_cnt == c_TMO_LIMIT);
        // Losing the timebase or the enable beats any qpps on the same cycle.
        go_idle   = ~pps_valid_i | ~en_i | timeout;
        load      = qpps & ~go_idle;
    end

    // FSM next state: abort to IDLE first, otherwise advance on qpps.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
        state_next = state;
        if (go_idle) begin
            state_next = ST_IDLE;
        end else if (qpps) begin
            case (state)
                ST_IDLE:  state_next = ST_FIRST;
                ST_FIRST: state_next = ST_RUN;
                default:  state_next = ST_RUN;
            endcase
        end
    end

    // Interval counters: restart on qpps with this cycle's contribution, saturate at all-ones.
    always_comb begin
        acc_sum    = '0;
        carry      = 1'b0;
        acc_next   = '0;
        kbps_base  = '0;
        kbps_next  = '0;
        frame_base = '0;
        frame_next = '0;
        count_en   = ~go_idle & ((state != ST_IDLE) | qpps);
        if (count_en) begin
            // acc stays below 1000 and a beat adds at most 16, so one carry per cycle suffices.
            acc_sum    = (qpps ? 10'd0 : acc) + {5'd0, beat_bits};
            carry      = (acc_sum >= c_KBIT);
            acc_next   = carry ? (acc_sum - c_KBIT) : acc_sum;
            kbps_base  = qpps ? '0 : kbps_cnt;
            frame_base = qpps ? '0 : frame_cnt;
            kbps_next  = (carry && kbps_base != c_CNT_MAX) ? kbps_base + c_CNT_ONE : kbps_base;
            frame_next = (frame_end && frame_base != c_CNT_MAX) ? frame_base + c_CNT_ONE
                                                                 : frame_base;
        end
    end

    // Cycles since the last qpps; cleared by qpps and whenever we are (or go) idle.
    always_comb begin
        tmo_next = tmo_cnt + c_TMO_ONE;
        if (qpps || state_next == ST_IDLE) begin
            tmo_next = '0;
        end
    end

    // State, counters and published results.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= ST_IDLE;
            cyc_prev   <= 1'b0;
            acc        <= '0;
            kbps_cnt   <= '0;
            frame_cnt  <= '0;
            tmo_cnt    <= '0;
            bw_kbps_o  <= '0;
            frames_o   <= '0;
            bw_valid_o <= 1'b0;
            upd_p_o    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values (load sees old counts).
            state      <= state_next;
            cyc_prev   <= snk_i.cyc;
            acc        <= acc_next;
            kbps_cnt   <= kbps_next;
            frame_cnt  <= frame_next;
            tmo_cnt    <= tmo_next;
            bw_valid_o <= (state_next == ST_RUN);
            upd_p_o    <= load;
            if (load) begin
                bw_kbps_o <= kbps_cnt;
                frames_o  <= frame_cnt;
            end
        end
    end

endmodule

// File: doc/nic_bw_meter.md
NIC_BW_METER -- requirements
Module: nic_bw_meter

Interface
REQ-001 SHALL have parameter g_PPS_TIMEOUT, default 70000000, the clk_sys_i cycles without a qualified PPS before the measurement is invalidated.
REQ-002 SHALL have parameter g_CNT_WIDTH, default 32, the width of the kbps and frame counters.
REQ-003 SHALL have port clk_sys_i  in  1  system clock; the block uses one clock only.
REQ-004 SHALL have port rst_n_i  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port pps_p_i  in  1  single-cycle PPS pulse.
REQ-006 SHALL have port pps_valid_i  in  1  PPS qualifier.
REQ-007 SHALL have port en_i  in  1  metering enable.
REQ-008 SHALL have port snk_i  in  t_wrf_sink_in  upstream fabric (cyc, stb, adr[1:0], dat[15:0], sel[1:0]).
REQ-009 SHALL have port snk_o  out  t_wrf_sink_out  upstream ack/err/stall.
REQ-010 SHALL have port src_o  out  t_wrf_source_out  downstream fabric.
REQ-011 SHALL have port src_i  in  t_wrf_source_in  downstream ack/err/stall.
REQ-012 SHALL have port bw_kbps_o  out  g_CNT_WIDTH  kbps measured over the last full PPS interval.
REQ-013 SHALL have port frames_o  out  g_CNT_WIDTH  frames completed in the last full PPS interval.
REQ-014 SHALL have port bw_valid_o  out  1  high when bw_kbps_o and frames_o cover a full interval.
REQ-015 SHALL have port upd_p_o  out  1  one-cycle pulse when bw_kbps_o and frames_o are reloaded.

Function
REQ-016 SHALL pass the fabric through combinationally: src_o = snk_i and snk_o = src_i, with zero latency and no alteration, regardless of en_i or the measurement state.
REQ-017 SHALL define an accepted beat as snk_i.cyc & snk_i.stb & !src_i.stall & snk_i.adr == c_WRF_DATA; beats on OOB, status or user addresses are not counted.
REQ-018 SHALL credit each accepted beat with 16 bits when sel = "11" and 8 bits otherwise.
REQ-019 SHALL keep a 10-bit bit accumulator: add the beat bits each cycle; when the sum is >= 1000, subtract 1000 and increment kbps_cnt by 1 (at most one increment per cycle).
REQ-020 SHALL increment frame_cnt on each falling edge of snk_i.cyc, comparing the registered previous value of cyc.
REQ-021 SHALL saturate kbps_cnt and frame_cnt at all-ones with no wrap.
REQ-022 SHALL treat qpps = pps_p_i & pps_valid_i as a qualified PPS.
REQ-023 SHALL, on qpps: load bw_kbps_o and frames_o from the counter values registered before this cycle; restart the accumulator and counters from 0 plus this cycle's beat and frame-end contribution; pulse upd_p_o one cycle later together with the new outputs.
REQ-024 SHALL implement an FSM with states IDLE, FIRST and RUN.
  - IDLE: reset state; qpps -> FIRST.
  - FIRST: partial interval; qpps -> RUN and bw_valid_o <= 1.
  - RUN: qpps -> RUN.
  - Any state: pps_valid_i = 0, en_i = 0, or a timeout -> IDLE with bw_valid_o <= 0 in the next cycle.
REQ-025 SHALL in IDLE hold the counters and accumulator at 0, and leave bw_kbps_o and frames_o at their last values.
REQ-026 SHALL count clk_sys_i cycles since the last qpps; reaching g_PPS_TIMEOUT forces IDLE, and the counter is cleared by qpps and in IDLE.
REQ-027 SHALL still perform the load of REQ-023 on a qpps arriving in FIRST, but SHALL keep bw_valid_o low until the FIRST->RUN transition.
REQ-028 SHALL give the IDLE exit priority over all other transitions when qpps coincides with en_i = 0.

Reset
REQ-029 SHALL on rst_n_i low immediately set the following to 0 regardless of clock: bw_kbps_o, frames_o, bw_valid_o, upd_p_o, the counters, the accumulator, the timeout counter and the registered cyc; the FSM SHALL reset to IDLE.
REQ-030 SHALL keep the passthrough combinational and active during reset.
REQ-031 SHALL, after a reset mid-frame, not count the frame end that occurs while still in IDLE.

Structure
REQ-032 SHALL take t_wrf_sink_in/out, t_wrf_source_in/out and c_WRF_DATA from wr_fabric_pkg.
REQ-033 SHALL place the constant c_BITS_PER_KBIT = 1000 and the FSM state type in the shared package as well.
REQ-034 SHALL keep the block a single module, with no sub-modules.

Verification
REQ-035 SHALL cover: reset, no traffic, qpps at t0 and t0+N -> bw_valid_o = 1 after the second qpps, bw_kbps_o = 0, frames_o = 0, two upd_p_o pulses.
REQ-036 SHALL cover: between qpps 2 and 3, 125 frames of 500 full-sel data words -> bw_kbps_o = 1000, frames_o = 125.
REQ-037 SHALL cover: 25 frames of 3 data words with the last sel = "10" (40 bits each) -> bw_kbps_o = 1, frames_o = 25.
REQ-038 SHALL cover: a 100-word frame with stall asserted on 50 beats (stb held) -> only 100 beats counted, and src_o/snk_o equal to snk_i/src_i every cycle.
REQ-039 SHALL cover: a full-sel beat on the qpps cycle -> excluded from the latched value and counted as 16 bits in the new interval.
REQ-040 SHALL cover: pps_valid_i dropped mid-RUN -> bw_valid_o = 0 next cycle, and two further qpps are needed before bw_valid_o = 1; the same holds with g_PPS_TIMEOUT = 100 and no PPS for 100 cycles.
